// File: rtl/kyber_bits_pkg.sv
// Shared constants and types for the Kyber bit/byte packing stages.
// Holds the frame-size limit, datapath widths and the packer state encoding.
package kyber_bits_pkg;

  localparam int MAX_BYTES = 32;
  localparam int BYTE_W    = 8;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } b2b_state_t;

  // Requested frame lengths above the limit are clamped rather than rejected.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [7:0] req_len);
    logic [CNT_W-1:0] eff;
    if (req_len > 8'(MAX_BYTES)) begin
      eff = CNT_W'(MAX_BYTES);
    end else begin
      eff = req_len[CNT_W-1:0];
    end
    return eff;
  endfunction

endpackage

// File: rtl/bits_to_bytes_stream.sv
// Streaming BitsToBytes packer: serial LSB-first bits in, bytes out on a
// valid/ready stream with a single-entry output register and last-byte flag.
module bits_to_bytes_stream
  import kyber_bits_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        len,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              bit_ready,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_last,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done
);

  b2b_state_t        state_r;
  b2b_state_t        next_state_s;
  logic [CNT_W-1:0]  eff_len_r;
  logic [CNT_W-1:0]  start_len_s;
  logic [CNT_W-1:0]  byte_cnt_r;
  logic [2:0]        bit_cnt_r;
  logic [BYTE_W-1:0] acc_r;
  logic [BYTE_W-1:0] byte_out_r;
  logic              byte_valid_r;
  logic              byte_last_r;
  logic              busy_r;
  logic              done_r;
  logic              start_ok_s;
  logic              bit_ready_s;
  logic              bit_fire_s;
  logic              byte_load_s;
  logic              last_byte_s;
  logic              byte_take_s;

  // Handshake qualifiers; byte_ready reaches bit_ready combinationally so the
  // input only stalls when a fresh byte would overwrite an untaken one.
  always_comb begin
    start_len_s = clamp_len(len);
    start_ok_s  = (state_r == IDLE) && start;
    bit_ready_s = (state_r == COLLECT) &&
                  ((bit_cnt_r != 3'd7) || !byte_valid_r || byte_ready);
    bit_fire_s  = bit_ready_s && bit_valid;
    byte_load_s = bit_fire_s && (bit_cnt_r == 3'd7);
    last_byte_s = (byte_cnt_r == (eff_len_r - 6'd1));
    byte_take_s = byte_valid_r && byte_ready;
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          next_state_s = (start_len_s == 6'd0) ? DONE : COLLECT;
        end else begin
          next_state_s = IDLE;
        end
      end
      COLLECT: begin
        if (byte_load_s && last_byte_s) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = COLLECT;
        end
      end
      DRAIN: begin
        if (byte_take_s && byte_last_r) begin
          next_state_s = DONE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register with registered status flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
      done_r  <= (next_state_s == DONE);
    end
  end

  // Frame length is captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      eff_len_r <= 6'd0;
    end else if (start_ok_s) begin
      eff_len_r <= start_len_s;
    end else begin
      eff_len_r <= eff_len_r;
    end
  end

  // Bit/byte position counters; bit_cnt wraps naturally from 7 to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 6'd0;
    end else if (start_ok_s) begin
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 6'd0;
    end else begin
      if (bit_fire_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      if (byte_load_s) begin
        byte_cnt_r <= byte_cnt_r + 6'd1;
      end else begin
        byte_cnt_r <= byte_cnt_r;
      end
    end
  end

  // Partial-byte accumulator; the 8th bit bypasses it straight into byte_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= 8'h00;
    end else if (start_ok_s || byte_load_s) begin
      acc_r <= 8'h00;
    end else if (bit_fire_s) begin
      acc_r[bit_cnt_r] <= bit_in;
    end else begin
      acc_r <= acc_r;
    end
  end

  // Single-entry output buffer; a load in the same cycle as a take wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_out_r   <= 8'h00;
      byte_valid_r <= 1'b0;
      byte_last_r  <= 1'b0;
    end else if (byte_load_s) begin
      byte_out_r   <= {bit_in, acc_r[6:0]};
      byte_valid_r <= 1'b1;
      byte_last_r  <= last_byte_s;
    end else if (byte_take_s) begin
      byte_out_r   <= byte_out_r;
      byte_valid_r <= 1'b0;
      byte_last_r  <= 1'b0;
    end else begin
      byte_out_r   <= byte_out_r;
      byte_valid_r <= byte_valid_r;
      byte_last_r  <= byte_last_r;
    end
  end

  assign bit_ready  = bit_ready_s;
  assign byte_valid = byte_valid_r;
  assign byte_out   = byte_out_r;
  assign byte_last  = byte_last_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_bits_to_bytes_stream.sv
// Directed, table-driven bench for bits_to_bytes_stream: each table row is a
// frame whose bytes follow first + k*step, plus a hand-written mid-frame reset.
module tb_bits_to_bytes_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       bit_valid;
  logic       bit_in;
  logic       bit_ready;
  logic       byte_valid;
  logic [7:0] byte_out;
  logic       byte_last;
  logic       byte_ready;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  bits_to_bytes_stream dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .bit_ready  (bit_ready),
    .byte_valid (byte_valid),
    .byte_out   (byte_out),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] len;
    logic [7:0] first;
    logic [7:0] step;
    int         exp_n;
    int         stall;
    int         exp_low;
    bit         inj;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] first, input logic [7:0] step, input int k);
    logic [7:0] kk;
    kk = k[7:0];
    return first + kk * step;
  endfunction

  task automatic run_frame(input vec_t v);
    int         bi, got, total, last_take, f7, fv, low_cnt, stall_cnt, lb;
    bit         done_seen;
    logic [7:0] cur;
    total = 8 * v.exp_n;
    bi = 0; got = 0; last_take = -1; f7 = -1; fv = -1;
    low_cnt = 0; stall_cnt = 0; lb = -1; done_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; len = v.len; bit_valid = 1'b0; byte_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 1000 && !done_seen; cyc++) begin
      start = (v.inj && cyc == 10);
      len   = start ? 8'd5 : v.len;
      if (byte_valid && fv < 0) fv = cyc;
      bit_valid = (bi < total);
      cur = exp_byte(v.first, v.step, bi / 8);
      bit_in = bit_valid ? cur[bi % 8] : 1'b0;
      if (v.stall > 0 && fv >= 0 && stall_cnt < v.stall) begin
        byte_ready = 1'b0;
        stall_cnt++;
      end else begin
        byte_ready = 1'b1;
      end
      #1;
      if (byte_valid && !byte_ready) check("hold_byte", byte_out, exp_byte(v.first, v.step, got));
      if (bit_valid && !bit_ready) begin
        low_cnt++;
        check("stall_pos", bi, 15);
      end
      if (byte_valid && byte_ready) begin
        check("byte_data", byte_out, exp_byte(v.first, v.step, got));
        check("byte_last", byte_last, (got == v.exp_n - 1));
        got++;
        last_take = cyc;
      end
      if (bit_valid && bit_ready) begin
        if (bi == 7) f7 = cyc;
        lb = cyc;
        bi++;
      end
      if (done) begin
        done_seen = 1'b1;
        check("done_timing", cyc, last_take + 1);
        check("byte_count", got, v.exp_n);
        check("bits_consumed", bi, total);
      end
      @(negedge clk);
    end
    start = 1'b0; bit_valid = 1'b0; byte_ready = 1'b1;
    check("done_seen", done_seen, 1);
    check("low_cycles", low_cnt, v.exp_low);
    if (v.exp_n > 0) begin
      check("valid_rise", fv, f7 + 1);
      if (v.exp_low == 0) check("bit_cycles", lb, total - 1);
    end else begin
      check("no_bytes", fv, -1);
    end
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    check("valid_idle", byte_valid, 0);
  endtask

  initial begin
    vecs[0] = '{8'd1,  8'h0D, 8'h00, 1,  0,  0,  1'b0};
    vecs[1] = '{8'd32, 8'h00, 8'h01, 32, 0,  0,  1'b0};
    vecs[2] = '{8'd2,  8'hA5, 8'h97, 2,  20, 13, 1'b0};
    vecs[3] = '{8'd0,  8'h00, 8'h00, 0,  0,  0,  1'b0};
    vecs[4] = '{8'd40, 8'h40, 8'h03, 32, 0,  0,  1'b0};
    vecs[5] = '{8'd3,  8'hF0, 8'h11, 3,  0,  0,  1'b1};

    rst = 1'b1; start = 1'b0; len = 8'd0;
    bit_valid = 1'b0; bit_in = 1'b0; byte_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_out", byte_out, 0);
    check("rst_byte_last", byte_last, 0);
    check("rst_bit_ready", bit_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i]);
    end

    // Mid-frame reset after 13 accepted bits with the first byte left untaken.
    @(negedge clk);
    start = 1'b1; len = 8'd4; byte_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      bit_valid = 1'b1;
      bit_in = i[0];
      @(negedge clk);
    end
    bit_valid = 1'b0;
    check("pre_rst_valid", byte_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_byte_valid", byte_valid, 0);
    check("mid_rst_byte_out", byte_out, 0);
    check("mid_rst_byte_last", byte_last, 0);
    check("mid_rst_bit_ready", bit_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    rst = 1'b0; byte_ready = 1'b1;
    run_frame('{8'd1, 8'h5A, 8'h00, 1, 0, 0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bits_to_bytes_stream.md
# bits_to_bytes_stream

Streaming BitsToBytes packer for the Kyber-768-90s datapath. It accepts a serial bit stream with a valid/ready handshake. Bit i of a frame goes to byte i/8, bit position i mod 8, LSB first. Each completed byte is emitted on a valid/ready byte stream, for up to 32 bytes per frame. It is the sequential inverse of the combinational byte-to-bit unpacker and feeds encoding and serialization stages.

## Interface
- MAX_BYTES, 32, maximum bytes per frame; larger requests are clamped to this value.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame start pulse; sampled only in IDLE.
- len  input  8  frame length in bytes; latched on an accepted start.
- bit_valid  input  1  bit_in is valid.
- bit_in  input  1  next bit of the frame, in stream order.
- bit_ready  output  1  the packer accepts bit_in this cycle.
- byte_valid  output  1  byte_out holds a valid byte.
- byte_out  output  8  packed byte.
- byte_last  output  1  qualifies the final byte of the frame.
- byte_ready  input  1  the downstream stage takes byte_out this cycle.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse at frame completion.

## Operation
- Effective length: eff_len = min(len, MAX_BYTES), latched as a 6-bit value at start.
- States:
  - IDLE: waiting for start.
  - COLLECT: accepting bits.
  - DRAIN: every bit has been accepted; the final byte is waiting for its handshake.
  - DONE: one cycle; done=1; the next state is always IDLE.
- IDLE -> COLLECT on start when eff_len > 0.
- IDLE -> DONE on start when eff_len == 0. No bytes are emitted.
- start outside IDLE is ignored, and len is not re-latched.
- Counters: bit_cnt (3 bits) counts bit position within the current byte. byte_cnt (6 bits) counts bytes packed so far.
- An accepted bit is written to acc[bit_cnt], then bit_cnt increments and wraps from 7 to 0.
- On the 8th bit (bit_cnt == 7), the output register loads {bit_in, acc[6:0]} and byte_valid is set.
  - byte_last is set if byte_cnt == eff_len-1.
  - byte_cnt increments and acc clears.
  - If this byte is the last one, the state goes to DRAIN.
- bit_ready = (state == COLLECT) && (bit_cnt != 7 || !byte_valid || byte_ready).
  - Stalls occur only when a new byte would overwrite an untaken byte.
  - The path from byte_ready to bit_ready is combinational by design.
- Byte handshake: on byte_valid && byte_ready, byte_valid clears unless a new byte loads in the same cycle.
- DRAIN -> DONE on the handshake of the byte with byte_last set.
- Values held while stalled: byte_out, byte_last and byte_valid stay stable while byte_valid=1 and byte_ready=0.
- Bits offered while bit_ready=0 are not consumed. bit_in is don't-care when bit_valid=0.

## Timing
- Reset values: state=IDLE; acc, bit_cnt and byte_cnt are 0; byte_out=0x00; byte_valid, byte_last, bit_ready, busy and done are all 0.
- rst mid-frame clears everything to the reset values in the same edge, and any partial byte is discarded.
- busy goes high the cycle after an accepted start.
- bit_ready is high from the first cycle in COLLECT.
- byte_valid rises the cycle after the 8th bit of a byte is accepted.
- With continuous bit_valid and byte_ready=1, a frame runs 8*eff_len bit cycles. done then pulses the cycle after the last byte's handshake.
- Throughput is 1 bit/clk with no bubble between bytes.
- Output slack: byte k may wait up to 7 cycles for its handshake without stalling input, because bit_ready drops only at bit_cnt == 7.
- When the final byte is handed off in the same cycle a byte loads, the load wins: byte_valid stays 1 with the new data.
- A new start is accepted in the cycle after done, that is, in IDLE.

## Structure
- Shared package kyber_bits_pkg holds:
  - the MAX_BYTES constant (32);
  - the localparams BYTE_W=8 and CNT_W=6;
  - the state enum b2b_state_t {IDLE, COLLECT, DRAIN, DONE}.
- The block is a single module with no sub-modules. The output register is a single-entry buffer kept inline.

## Test plan
- len=1, bits 1,0,1,1,0,0,0,0 (first bit to bit0), byte_ready=1 -> one byte 0x0D with byte_last=1. byte_valid is one cycle after the 8th bit, done one cycle after the handshake, busy=0 afterward.
- len=32, bit stream encoding bytes 0x00..0x1F LSB-first, continuous valid/ready -> 32 bytes in order, only byte 0x1F with last=1, bit_ready never low in COLLECT, frame completes in 256 bit cycles.
- len=2, byte_ready=0 for 20 cycles after the first byte -> bit_ready low exactly at bit_cnt 7 of byte 1. Byte 0 stays held and no bit is lost. Output is 0xA5 then 0x3C, given stream bits for 0xA5, 0x3C.
- len=0 -> done the cycle after start, no byte_valid. len=40 -> exactly 32 bytes, last on the 32nd.
- rst asserted after 13 accepted bits of a len=4 frame -> all outputs at reset values next cycle. A new len=1 frame then produces the correct byte.
- start pulsed with len=5 during an active len=3 frame -> ignored, and exactly 3 bytes are emitted.
